seq_stage_controller: RTL and testbench
=======================================

// Module: seq_stage_controller
// PURPOSE
//  Sequences the SEQ Y86-64 datapath through six stages; one instruction at a time.
//  Owns the architectural PC register and selects the next PC (jXX/call/ret/default).
//  Tracks processor status (AOK/HLT/ADR/INS) and stops on any non-AOK condition.
//  Sits between the fetch/decode/execute/memory/writeback units and the top level.
// PARAMETERS
//  PC_W         64   PC and value-bus width
//  RESET_PC     0    PC loaded on reset
//  MEM_WAIT_MAX 15   max cycles MEMORY waits for mem_done before ADR fault
// PORTS
//  clk          in   1     single clock, all state on rising edge
//  rst          in   1     synchronous, active-high reset
//  run          in   1     level; start/continue execution
//  icode        in   4     instruction code from fetch
//  instr_valid  in   1     fetch decoded a legal instruction
//  imem_error   in   1     fetch address error
//  cnd          in   1     condition result from execute
//  valC         in   PC_W  constant word from fetch
//  valP         in   PC_W  fall-through PC from fetch
//  valM         in   PC_W  data memory read value
//  mem_done     in   1     data memory access complete
//  dmem_error   in   1     data memory address error, valid with mem_done
//  pc           out  PC_W  current PC
//  fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out 1 each  stage strobes
//  stat         out  3     1=AOK 2=HLT 3=ADR 4=INS
//  halted       out  1     processor stopped (stat != AOK)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, stat=1, halted=0, all strobes 0, wait cnt 0.
//    rst wins over every other input in any state, incl. mid-MEMORY.
//  - States: IDLE,FETCH,DECODE,EXECUTE,MEMORY,WRITEBACK,PCUPD,HALT. Exactly one
//    strobe high per state (registered, coincident with state); none in IDLE/HALT.
//  - IDLE: run=1 -> FETCH next cycle; else stay.
//  - FETCH (1 cyc): latch icode,valC,valP. imem_error -> stat=3, HALT;
//    else !instr_valid -> stat=4, HALT; else icode==0 -> stat=2, HALT; else DECODE.
//    Priority ADR > INS > HLT. PC unchanged on any fault.
//  - DECODE (1 cyc) -> EXECUTE. EXECUTE (1 cyc): latch cnd -> MEMORY.
//  - MEMORY: icode in {4,5,8,9,A,B}: mem_en held until mem_done; at mem_done latch
//    valM; dmem_error -> stat=3, HALT (no writeback, no PC update); else WRITEBACK.
//    Wait count increments each cycle without mem_done; reaching MEM_WAIT_MAX ->
//    stat=3, HALT. mem_done in first MEMORY cycle = zero wait. Other icodes: 1 cyc.
//  - WRITEBACK (1 cyc) -> PCUPD.
//  - PCUPD (1 cyc): pc <= (icode==7) ? (cnd?valC:valP) : (icode==8) ? valC :
//    (icode==9) ? valM : valP. Uses latched copies only. Then run ? FETCH : IDLE.
//  - Non-memory instruction: 6 cycles FETCH..PCUPD; memory instr: 6 + wait cycles.
//  - HALT: sticky until rst; pc, stat held; halted=1; run ignored.
//  - pc wraps modulo 2^PC_W; no overflow detection.
// CONFIGURATION
//  PC_PERF_EN defined: adds out ports instr_retired[31:0] (+1 per PCUPD) and
//   cycle_count[31:0] (+1 every non-IDLE, non-HALT cycle); both wrap, reset to 0,
//   freeze in HALT. Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 rst 2 cyc, run=1; icode=1(nop),valP=0x1 -> FETCH..PCUPD 6 cyc, pc=0x1, stat=1.
//  2 icode=7,valC=0x40,valP=0x9: cnd=1 -> pc=0x40; cnd=0 -> pc=0x9.
//  3 icode=8,valC=0x100 -> pc=0x100; then icode=9, mem_done after 3 cyc,
//    valM=0x13 -> pc=0x13, total 9 cyc.
//  4 icode=5, mem_done never -> after 15 MEMORY cyc stat=3, halted=1, pc unchanged.
//  5 icode=0 -> stat=2, HALT; run toggled -> no strobes; rst -> pc=0, stat=1.
//  6 instr_valid=0 with imem_error=1 -> stat=3; rst asserted during MEMORY -> IDLE
//    next cycle, mem_en=0, pc=RESET_PC.

Source files
------------

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: six-stage sequencer for the SEQ Y86-64 datapath.
// Runs one instruction at a time through FETCH..PCUPD, owns the architectural PC
// and tracks processor status, stopping on any non-AOK condition.
// Optional feature: define PC_PERF_EN to add instr_retired/cycle_count counters.

module seq_stage_controller #(
   parameter int unsigned       PC_W         = 64,
   parameter logic [PC_W-1:0]   RESET_PC     = '0,
   parameter int unsigned       MEM_WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [3:0]      icode,
   input  logic            instr_valid,
   input  logic            imem_error,
   input  logic            cnd,
   input  logic [PC_W-1:0] valC,
   input  logic [PC_W-1:0] valP,
   input  logic [PC_W-1:0] valM,
   input  logic            mem_done,
   input  logic            dmem_error,
   output logic [PC_W-1:0] pc,
   output logic            fetch_en,
   output logic            decode_en,
   output logic            exec_en,
   output logic            mem_en,
   output logic            wb_en,
   output logic            pc_en,
   output logic [2:0]      stat,
   output logic            halted
`ifdef PC_PERF_EN
   ,
   output logic [31:0]     instr_retired,
   output logic [31:0]     cycle_count
`endif
);

   localparam int unsigned WaitW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_WAIT_MAX);

   localparam logic [2:0] StatAok = 3'd1;
   localparam logic [2:0] StatHlt = 3'd2;
   localparam logic [2:0] StatAdr = 3'd3;
   localparam logic [2:0] StatIns = 3'd4;

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalt
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [2:0]        stat_q, stat_d;
   logic [3:0]        icode_q, icode_d;
   logic [PC_W-1:0]   valc_q, valc_d;
   logic [PC_W-1:0]   valp_q, valp_d;
   logic [PC_W-1:0]   valm_q, valm_d;
   logic              cnd_q, cnd_d;
   logic [WaitW-1:0]  wait_q, wait_d;
   logic [5:0]        strobe_q, strobe_d;  // {pc, wb, mem, exec, decode, fetch}

   logic              is_mem;
   logic [WaitW-1:0]  wait_inc;
   logic [PC_W-1:0]   next_pc;

   assign is_mem   = (icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
   assign wait_inc = wait_q + 1'b1;
   // Next PC is formed only from copies latched during this instruction.
   assign next_pc  = (icode_q == 4'h7) ? (cnd_q ? valc_q : valp_q) :
                     (icode_q == 4'h8) ? valc_q :
                     (icode_q == 4'h9) ? valm_q : valp_q;

   // State register; reset overrides everything, including a pending memory wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath latches, PC, status, wait counter and registered stage strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         stat_q   <= StatAok;
         icode_q  <= '0;
         valc_q   <= '0;
         valp_q   <= '0;
         valm_q   <= '0;
         cnd_q    <= 1'b0;
         wait_q   <= '0;
         strobe_q <= '0;
      end else begin
         pc_q     <= pc_d;
         stat_q   <= stat_d;
         icode_q  <= icode_d;
         valc_q   <= valc_d;
         valp_q   <= valp_d;
         valm_q   <= valm_d;
         cnd_q    <= cnd_d;
         wait_q   <= wait_d;
         strobe_q <= strobe_d;
      end
   end

   // Next-state, latch enables and strobes decoded from the next state.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stat_d  = stat_q;
      icode_d = icode_q;
      valc_d  = valc_q;
      valp_d  = valp_q;
      valm_d  = valm_q;
      cnd_d   = cnd_q;
      wait_d  = wait_q;
      unique case (state_q)
         StIdle: begin
            if (run) state_d = StFetch;
         end
         StFetch: begin
            icode_d = icode;
            valc_d  = valC;
            valp_d  = valP;
            if (imem_error) begin
               stat_d  = StatAdr;
               state_d = StHalt;
            end else if (!instr_valid) begin
               stat_d  = StatIns;
               state_d = StHalt;
            end else if (icode == 4'h0) begin
               stat_d  = StatHlt;
               state_d = StHalt;
            end else begin
               state_d = StDecode;
            end
         end
         StDecode: state_d = StExecute;
         StExecute: begin
            cnd_d   = cnd;
            wait_d  = '0;
            state_d = StMemory;
         end
         StMemory: begin
            if (!is_mem) begin
               state_d = StWriteback;
            end else if (mem_done) begin
               valm_d = valM;
               if (dmem_error) begin
                  stat_d  = StatAdr;
                  state_d = StHalt;
               end else begin
                  state_d = StWriteback;
               end
            end else if (wait_inc == WaitMax) begin
               // Memory never answered: treat as an address fault.
               stat_d  = StatAdr;
               state_d = StHalt;
            end else begin
               wait_d = wait_inc;
            end
         end
         StWriteback: state_d = StPcupd;
         StPcupd: begin
            pc_d    = next_pc;
            state_d = run ? StFetch : StIdle;
         end
         StHalt: state_d = StHalt;
      endcase

      strobe_d = '0;
      unique case (state_d)
         StFetch:     strobe_d[0] = 1'b1;
         StDecode:    strobe_d[1] = 1'b1;
         StExecute:   strobe_d[2] = 1'b1;
         StMemory:    strobe_d[3] = 1'b1;
         StWriteback: strobe_d[4] = 1'b1;
         StPcupd:     strobe_d[5] = 1'b1;
         default:     strobe_d    = '0;
      endcase
   end

   assign pc        = pc_q;
   assign stat      = stat_q;
   assign halted    = (stat_q != StatAok);
   assign fetch_en  = strobe_q[0];
   assign decode_en = strobe_q[1];
   assign exec_en   = strobe_q[2];
   assign mem_en    = strobe_q[3];
   assign wb_en     = strobe_q[4];
   assign pc_en     = strobe_q[5];

`ifdef PC_PERF_EN
   logic [31:0] retired_q, cycles_q;

   // Performance counters; both freeze once the processor has stopped.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
         cycles_q  <= '0;
      end else begin
         if (state_q == StPcupd) retired_q <= retired_q + 32'd1;
         if (state_q != StIdle && state_q != StHalt) cycles_q <= cycles_q + 32'd1;
      end
   end

   assign instr_retired = retired_q;
   assign cycle_count   = cycles_q;
`endif

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized self-checking bench for seq_stage_controller against an
// instruction-level reference model (expected stage sequence, PC and status).

module tb_seq_stage_controller;

   localparam int MEM_WAIT_MAX = 15;
   localparam logic [5:0] SF = 6'b000001;
   localparam logic [5:0] SD = 6'b000010;
   localparam logic [5:0] SE = 6'b000100;
   localparam logic [5:0] SM = 6'b001000;
   localparam logic [5:0] SW = 6'b010000;
   localparam logic [5:0] SP = 6'b100000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [3:0]  icode = '0;
   logic        instr_valid = 1'b0;
   logic        imem_error = 1'b0;
   logic        cnd = 1'b0;
   logic [63:0] valC = '0;
   logic [63:0] valP = '0;
   logic [63:0] valM = '0;
   logic        mem_done = 1'b0;
   logic        dmem_error = 1'b0;
   logic [63:0] pc;
   logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
   logic [2:0]  stat;
   logic        halted;
   logic [5:0]  strobes;
`ifdef PC_PERF_EN
   logic [31:0] instr_retired, cycle_count;
`endif

   assign strobes = {pc_en, wb_en, mem_en, exec_en, decode_en, fetch_en};

   seq_stage_controller dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .icode       (icode),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .cnd         (cnd),
      .valC        (valC),
      .valP        (valP),
      .valM        (valM),
      .mem_done    (mem_done),
      .dmem_error  (dmem_error),
      .pc          (pc),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .exec_en     (exec_en),
      .mem_en      (mem_en),
      .wb_en       (wb_en),
      .pc_en       (pc_en),
      .stat        (stat),
      .halted      (halted)
`ifdef PC_PERF_EN
      ,
      .instr_retired (instr_retired),
      .cycle_count   (cycle_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic [63:0] exp_pc;
   logic [2:0]  exp_stat;
   logic        model_halt;
   int          ret_cnt;
   int          cyc_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      exp_pc     = '0;
      exp_stat   = 3'd1;
      model_halt = 1'b0;
      ret_cnt    = 0;
      cyc_cnt    = 0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      run      = 1'($urandom);
      mem_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      check("rst_strobes", strobes, 6'b0);
      check("rst_pc", pc, exp_pc);
      check("rst_stat", stat, exp_stat);
      check("rst_halted", halted, 1'b0);
      rst = 1'b0;
      run = 1'b1;
   endtask

   // One instruction: builds the expected stage sequence, drives inputs the way
   // the surrounding units would, checks every cycle. rst_at >= 0 aborts with
   // a reset asserted after that sequence position.
   task automatic do_instr(input logic [3:0] ic, input logic iv, input logic ime,
                           input logic c, input logic [63:0] vc, input logic [63:0] vp,
                           input logic [63:0] vm, input int w, input logic de,
                           input int rst_at);
      logic [5:0] seq[$];
      logic       is_mem, halt, done;
      logic [2:0] st;
      int         mcnt;
      is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      halt = 1'b0;
      done = 1'b0;
      st   = 3'd1;
      seq.push_back(SF);
      if (ime) begin
         halt = 1'b1; st = 3'd3;
      end else if (!iv) begin
         halt = 1'b1; st = 3'd4;
      end else if (ic == 4'h0) begin
         halt = 1'b1; st = 3'd2;
      end else begin
         seq.push_back(SD);
         seq.push_back(SE);
         if (!is_mem) begin
            seq.push_back(SM); seq.push_back(SW); seq.push_back(SP);
            done = 1'b1;
         end else if (w >= MEM_WAIT_MAX) begin
            repeat (MEM_WAIT_MAX) seq.push_back(SM);
            halt = 1'b1; st = 3'd3;
         end else begin
            repeat (w + 1) seq.push_back(SM);
            if (de) begin
               halt = 1'b1; st = 3'd3;
            end else begin
               seq.push_back(SW); seq.push_back(SP);
               done = 1'b1;
            end
         end
      end

      icode = ic; instr_valid = iv; imem_error = ime; valC = vc; valP = vp;
      mcnt = 0;
      foreach (seq[i]) begin
         @(posedge clk);
         @(negedge clk);
         check("strobes", strobes, seq[i]);
         check("pc_run", pc, exp_pc);
         check("stat_run", stat, 3'd1);
         check("halted_run", halted, 1'b0);
         if (i == rst_at) begin
            rst = 1'b1;
            mem_done = 1'b0;
            @(posedge clk);
            @(negedge clk);
            model_reset();
            check("midrst_strobes", strobes, 6'b0);
            check("midrst_pc", pc, exp_pc);
            check("midrst_stat", stat, exp_stat);
            check("midrst_halted", halted, 1'b0);
            rst = 1'b0;
            run = 1'b1;
            return;
         end
         case (seq[i])
            SD: begin
               // Fetch inputs change after FETCH; the DUT must use its latched copy.
               icode = 4'($urandom); instr_valid = 1'($urandom); imem_error = 1'($urandom);
               valC = {$urandom, $urandom}; valP = {$urandom, $urandom};
               cnd = c;
               mem_done = 1'($urandom); dmem_error = 1'($urandom);
            end
            SE: ;
            SM: begin
               cnd = 1'($urandom);
               if (is_mem && mcnt == w) begin
                  mem_done = 1'b1; dmem_error = de; valM = vm;
               end else begin
                  mem_done = is_mem ? 1'b0 : 1'($urandom);
                  dmem_error = 1'($urandom);
                  valM = {$urandom, $urandom};
               end
               mcnt++;
            end
            default: begin
               mem_done = 1'($urandom); dmem_error = 1'($urandom);
            end
         endcase
      end
      cyc_cnt += seq.size();
      if (done) begin
         ret_cnt++;
         if (ic == 4'h7)      exp_pc = c ? vc : vp;
         else if (ic == 4'h8) exp_pc = vc;
         else if (ic == 4'h9) exp_pc = vm;
         else                 exp_pc = vp;
      end
      if (halt) begin
         exp_stat   = st;
         model_halt = 1'b1;
      end
   endtask

   // Stopped processor: no strobes, status and PC held, run ignored; then reset.
   task automatic halt_check();
      repeat (3) begin
         run = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("halt_strobes", strobes, 6'b0);
         check("halt_halted", halted, 1'b1);
         check("halt_stat", stat, exp_stat);
         check("halt_pc", pc, exp_pc);
`ifdef PC_PERF_EN
         check("perf_retired", instr_retired, 32'(ret_cnt));
         check("perf_cycles", cycle_count, 32'(cyc_cnt));
`endif
      end
      do_reset();
   endtask

   task automatic idle_gap(input int n);
      run = 1'b0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check("idle_strobes", strobes, 6'b0);
         check("idle_pc", pc, exp_pc);
      end
      run = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ic;
      logic [63:0] vc, vp, vm;
      int          w, r;
      model_reset();
      do_reset();
      // Directed cases.
      do_instr(4'h1, 1, 0, 0, 64'h0, 64'h1, 64'h0, 0, 0, -1);
      do_instr(4'h7, 1, 0, 1, 64'h40, 64'h9, 64'h0, 0, 0, -1);
      do_instr(4'h7, 1, 0, 0, 64'h40, 64'h9, 64'h0, 0, 0, -1);
      do_instr(4'h8, 1, 0, 0, 64'h100, 64'h12, 64'h0, 0, 0, -1);
      do_instr(4'h9, 1, 0, 0, 64'h0, 64'h10a, 64'h13, 3, 0, -1);
      do_instr(4'hB, 1, 0, 0, 64'h0, 64'h1234, 64'h55, 14, 0, -1);
      idle_gap(3);
      do_instr(4'h5, 1, 0, 0, 64'h0, 64'h20, 64'h0, 99, 0, -1);
      halt_check();
      do_instr(4'h0, 1, 0, 0, 64'h0, 64'h1, 64'h0, 0, 0, -1);
      halt_check();
      do_instr(4'h1, 0, 1, 0, 64'h0, 64'h1, 64'h0, 0, 0, -1);
      halt_check();
      do_instr(4'h1, 0, 0, 0, 64'h0, 64'h1, 64'h0, 0, 0, -1);
      halt_check();
      do_instr(4'h4, 1, 0, 0, 64'h0, 64'h30, 64'h0, 2, 1, -1);
      halt_check();
      do_instr(4'h1, 1, 0, 0, 64'h0, 64'h77, 64'h0, 0, 0, -1);
      do_instr(4'h4, 1, 0, 0, 64'h0, 64'h30, 64'h0, 10, 0, 5);
      do_instr(4'h7, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 0, 0, -1);
      // Randomized instruction stream.
      for (int n = 0; n < 250; n++) begin
         ic = 4'($urandom);
         vc = {$urandom, $urandom};
         vp = {$urandom, $urandom};
         vm = {$urandom, $urandom};
         r  = $urandom_range(0, 9);
         w  = (r < 6) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, 14) :
              $urandom_range(15, 20);
         do_instr(ic, ($urandom % 24) != 0, ($urandom % 24) == 0, 1'($urandom), vc, vp, vm,
                  w, ($urandom % 16) == 0,
                  (($urandom % 30) == 0) ? $urandom_range(0, 8) : -1);
         if (model_halt) halt_check();
         else if (($urandom % 8) == 0) idle_gap($urandom_range(1, 3));
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
